if_fetch_unit: RTL and testbench

- Instruction-fetch front end of the 5-stage ARM pipeline; the producer side of the IF/ID pipeline register.
- Owns the fetch PC and drives a variable-latency instruction-memory req/ack port.
- Presents {PC+4, Instruction} to the IF/ID register, honouring the hazard unit's freeze and EXE-stage branch redirects.
- Inserts a NOP bubble whenever no instruction is available.

---
 rtl/if_fetch_unit_pkg.sv | 31 +++
 rtl/if_fetch_unit_if.sv | 32 +++
 rtl/register.sv | 33 +++
 rtl/if_fetch_unit.sv | 176 +++++++++++++++++
 tb/tb_if_fetch_unit.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared definitions for the instruction-fetch front end of the 5-stage ARM
// pipeline: instruction width, reset/NOP defaults, the fetch FSM state type
// and the sequential-address helper.
// ---------------------------------------------------------------------------
package if_fetch_unit_pkg;

    localparam int INST_WIDTH = 32;

    localparam logic [INST_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [INST_WIDTH-1:0] DEFAULT_NOP_INST = 32'h0000_0000;

    // REQ     : a request to fetch_addr is outstanding on the memory port
    // HOLD    : a fetched word is parked in hold_buf while IF/ID is frozen
    // DISCARD : a branch arrived before the outstanding request completed;
    //           the response is thrown away and the target is fetched next
    typedef enum logic [1:0] {
        REQ     = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    // Next sequential word address; wraps mod 2^32.
    function automatic logic [INST_WIDTH-1:0] next_word_addr(
        input logic [INST_WIDTH-1:0] addr
    );
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
// Instruction-memory request/acknowledge port.
//   imem_req   : request valid (master -> slave)
//   imem_addr  : word address, stable while req=1 and no ack (master -> slave)
//   imem_rdata : instruction, valid only when imem_ack=1 (slave -> master)
//   imem_ack   : completes the request, may coincide with req (slave -> master)
// modport master is used by the fetch unit, modport slave by the memory.
// ---------------------------------------------------------------------------
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic                  imem_req;
    logic [INST_WIDTH-1:0] imem_addr;
    logic [INST_WIDTH-1:0] imem_rdata;
    logic                  imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );

endinterface

// File: rtl/register.sv
// ---------------------------------------------------------------------------
// Register
// Generic pipeline register with load enable and synchronous clear.
//   clk, rst : clock, asynchronous active-high reset (loads RESET_VALUE)
//   ld       : capture d on the rising edge
//   clr      : synchronous return to RESET_VALUE, dominates ld
//   d, q     : data in / registered data out
// ---------------------------------------------------------------------------
module Register #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear takes priority over load so a flush can never be overridden by
    // a simultaneous capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (clr) begin
            q <= RESET_VALUE;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch front end; producer side of the IF/ID pipeline register.
// Owns the fetch PC, drives a variable-latency instruction memory and presents
// {PC+4, Instruction} to IF/ID, honouring freeze and EXE branch redirects.
// A NOP bubble (inst_valid=0) is presented whenever no word is available.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   freeze       : IF/ID does not load this cycle; hold the presented word
//   branch_taken : redirect from EXE, higher priority than freeze
//   branch_addr  : redirect target
//   imem         : instruction-memory port (master side)
//   PC           : fetch address + 4 of the presented instruction
//   Instruction  : presented instruction or NOP_INST
//   inst_valid   : Instruction is a real fetched word
// ---------------------------------------------------------------------------
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [INST_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [INST_WIDTH-1:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [INST_WIDTH-1:0] branch_addr,
    if_fetch_unit_if.master       imem,
    output logic [INST_WIDTH-1:0] PC,
    output logic [INST_WIDTH-1:0] Instruction,
    output logic                  inst_valid
);

    fetch_state_t          state_q;
    fetch_state_t          state_d;

    logic [INST_WIDTH-1:0] fetch_addr;
    logic [INST_WIDTH-1:0] fetch_addr_d;
    logic                  fetch_addr_ld;

    logic [INST_WIDTH-1:0] target;
    logic [INST_WIDTH-1:0] target_d;
    logic                  target_ld;

    logic [INST_WIDTH-1:0] hold_buf;
    logic                  hold_buf_ld;

    Register #(.WIDTH(INST_WIDTH), .RESET_VALUE(RESET_PC)) u_fetch_addr (
        .clk (clk),
        .rst (rst),
        .ld  (fetch_addr_ld),
        .clr (1'b0),
        .d   (fetch_addr_d),
        .q   (fetch_addr)
    );

    Register #(.WIDTH(INST_WIDTH), .RESET_VALUE(RESET_PC)) u_target (
        .clk (clk),
        .rst (rst),
        .ld  (target_ld),
        .clr (1'b0),
        .d   (target_d),
        .q   (target)
    );

    Register #(.WIDTH(INST_WIDTH), .RESET_VALUE(NOP_INST)) u_hold_buf (
        .clk (clk),
        .rst (rst),
        .ld  (hold_buf_ld),
        .clr (1'b0),
        .d   (imem.imem_rdata),
        .q   (hold_buf)
    );

    // State register; reset lands in REQ so the first request to RESET_PC
    // is already on the port while rst is still asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and register-load decisions. Branch always beats freeze.
    // An ack outside REQ/DISCARD (i.e. in HOLD) is simply not looked at.
    always_comb begin
        state_d       = state_q;
        fetch_addr_ld = 1'b0;
        fetch_addr_d  = fetch_addr;
        target_ld     = 1'b0;
        target_d      = target;
        hold_buf_ld   = 1'b0;

        unique case (state_q)
            REQ: begin
                if (imem.imem_ack) begin
                    if (branch_taken) begin
                        // Fetched word belongs to the wrong path; go straight
                        // to the target without a DISCARD detour.
                        fetch_addr_ld = 1'b1;
                        fetch_addr_d  = branch_addr;
                    end else if (freeze) begin
                        hold_buf_ld = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        fetch_addr_ld = 1'b1;
                        fetch_addr_d  = next_word_addr(fetch_addr);
                    end
                end else if (branch_taken) begin
                    // Address must stay stable until ack, so remember the
                    // redirect and wait for the stale response.
                    target_ld = 1'b1;
                    target_d  = branch_addr;
                    state_d   = DISCARD;
                end
            end

            HOLD: begin
                if (branch_taken) begin
                    fetch_addr_ld = 1'b1;
                    fetch_addr_d  = branch_addr;
                    state_d       = REQ;
                end else if (!freeze) begin
                    fetch_addr_ld = 1'b1;
                    fetch_addr_d  = next_word_addr(fetch_addr);
                    state_d       = REQ;
                end
            end

            DISCARD: begin
                if (branch_taken) begin
                    target_ld = 1'b1;
                    target_d  = branch_addr;
                end
                if (imem.imem_ack) begin
                    fetch_addr_ld = 1'b1;
                    fetch_addr_d  = branch_taken ? branch_addr : target;
                    state_d       = REQ;
                end
            end

            default: begin
                state_d = REQ;
            end
        endcase
    end

    // Output selection. imem_req/imem_addr depend only on registered state,
    // so there is no path from imem_rdata to the request side.
    always_comb begin
        imem.imem_req  = (state_q != HOLD);
        imem.imem_addr = fetch_addr;
        Instruction    = NOP_INST;
        inst_valid     = 1'b0;
        PC             = next_word_addr(fetch_addr);

        if (state_q == REQ && imem.imem_ack) begin
            Instruction = imem.imem_rdata;
            inst_valid  = 1'b1;
        end else if (state_q == HOLD) begin
            Instruction = hold_buf;
            inst_valid  = 1'b1;
        end

        if (state_q == DISCARD) begin
            PC = next_word_addr(target);
        end

        if (branch_taken) begin
            inst_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Self-checking bench for if_fetch_unit: directed scenarios followed by a
// randomized phase, all compared against a behavioural fetch model.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] T_NOP      = 32'hE1A0_0000;
    localparam logic [31:0] BAD_DATA   = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        inst_valid;

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .RESET_PC (T_RESET_PC),
        .NOP_INST (T_NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem         (bus),
        .PC           (PC),
        .Instruction  (Instruction),
        .inst_valid   (inst_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: the address the front end is currently fetching,
    // whether a word is parked waiting for IF/ID, and whether the in-flight
    // response is known to be on the wrong path (with the redirect target).
    logic [31:0] m_fetch;
    logic [31:0] m_target;
    logic [31:0] m_held;
    bit          m_holding;
    bit          m_stale;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a | 32'hA000_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_fetch   = T_RESET_PC;
        m_target  = T_RESET_PC;
        m_held    = T_NOP;
        m_holding = 1'b0;
        m_stale   = 1'b0;
    endtask

    task automatic checkOutput();
        bit          have;
        logic [31:0] w;
        logic [31:0] pc_base;
        have = 1'b0;
        w    = T_NOP;
        if (m_holding) begin
            have = 1'b1;
            w    = m_held;
        end else if (!m_stale && bus.imem_ack) begin
            have = 1'b1;
            w    = word_of(m_fetch);
        end
        pc_base = m_stale ? m_target : m_fetch;
        chk("imem_req", {31'b0, bus.imem_req}, {31'b0, !m_holding});
        if (!m_holding) chk("imem_addr", bus.imem_addr, m_fetch);
        chk("Instruction", Instruction, w);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, have && !branch_taken});
        chk("PC", PC, pc_base + 32'd4);
    endtask

    // Advance the model by one clock using the inputs of the ending cycle.
    task automatic modelStep();
        if (m_holding) begin
            if (branch_taken) begin
                m_fetch   = branch_addr;
                m_holding = 1'b0;
            end else if (!freeze) begin
                m_fetch   = m_fetch + 32'd4;
                m_holding = 1'b0;
            end
        end else if (m_stale) begin
            if (branch_taken) m_target = branch_addr;
            if (bus.imem_ack) begin
                m_fetch = m_target;
                m_stale = 1'b0;
            end
        end else if (bus.imem_ack) begin
            if (branch_taken) begin
                m_fetch = branch_addr;
            end else if (freeze) begin
                m_holding = 1'b1;
                m_held    = word_of(m_fetch);
            end else begin
                m_fetch = m_fetch + 32'd4;
            end
        end else if (branch_taken) begin
            m_stale  = 1'b1;
            m_target = branch_addr;
        end
    endtask

    task automatic driveInputs(input bit f, input bit b, input logic [31:0] ba, input bit a);
        freeze         = f;
        branch_taken   = b;
        branch_addr    = ba;
        bus.imem_ack   = a;
        bus.imem_rdata = a ? word_of(m_fetch) : BAD_DATA;
    endtask

    // One full cycle: drive just after the rising edge, check on the falling
    // edge, then advance the model at the next rising edge.
    task automatic applyStimulus(input bit f, input bit b, input logic [31:0] ba, input bit a);
        driveInputs(f, b, ba, a);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        driveInputs(1'b0, 1'b0, 32'h0, 1'b0);
        modelReset();
        #2;
        $display("[TB] reset state");
        checkOutput();
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] zero-wait streaming");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] two wait states");
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] freeze on ack");
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] branch during wait");
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] second branch in discard");
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h80, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] branch with ack");
        applyStimulus(1'b0, 1'b1, 32'hC0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] freeze and branch together in hold");
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h100, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] async reset mid-wait");
        applyStimulus(1'b0, 1'b1, 32'h200, 1'b0);
        driveInputs(1'b0, 1'b0, 32'h0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput();
        chk("rst_addr", bus.imem_addr, T_RESET_PC);
        chk("rst_inst", Instruction, T_NOP);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] address wrap");
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        driveInputs(1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput();
        chk("wrap_pc", PC, 32'h0000_0000);
        @(posedge clk);
        modelStep();
        #1;
        chk("wrap_next_addr", bus.imem_addr, 32'h0000_0000);

        $display("[TB] randomized phase");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) < 30,
                          $urandom_range(0, 99) < 12,
                          $urandom & 32'hFFFF_FFFC,
                          $urandom_range(0, 99) < 55);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
